// File: rtl/counter_pulse_ctrl.sv
// Per-channel pulse sequencer for external counter ICs: low clock pulses, high reset pulses, then a recovery gap.
// Optional shadow count registers are built when COUNTER_PULSE_SHADOW_EN is defined.
//
// state | meaning
// IDLE  | waiting for a request; CTR_CLK high, CTR_RST low
// ADV   | CTR_CLK driven low for CLK_LOW_CYCLES
// CLR   | CTR_RST driven high for RST_HIGH_CYCLES
// GAP   | recovery for GAP_CYCLES, then DONE strobe on return to IDLE
module counter_pulse_ctrl #(
    parameter int NUM_CH          = 4,
    parameter int CLK_LOW_CYCLES  = 2,
    parameter int RST_HIGH_CYCLES = 2,
    parameter int GAP_CYCLES      = 1,
    parameter int SHADOW_W        = 8
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [NUM_CH-1:0]            ADV_REQ,
    input  logic [NUM_CH-1:0]            CLR_REQ,
    output logic [NUM_CH-1:0]            CTR_CLK,
    output logic [NUM_CH-1:0]            CTR_RST,
    output logic [NUM_CH-1:0]            BUSY,
    output logic [NUM_CH-1:0]            DONE,
    output logic [NUM_CH*SHADOW_W-1:0]   SHADOW_CNT
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADV  = 2'd1,
        S_CLR  = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    // Timers count down to zero, so each load is the phase length minus one.
    localparam logic [7:0] LOW_LOAD = 8'(CLK_LOW_CYCLES - 1);
    localparam logic [7:0] RST_LOAD = 8'(RST_HIGH_CYCLES - 1);
    localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES - 1);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        state_t     state, state_nxt;
        logic [7:0] timer, timer_nxt;
        logic       ctr_clk_q, ctr_clk_nxt;
        logic       ctr_rst_q, ctr_rst_nxt;
        logic       busy_q, busy_nxt;
        logic       done_q, done_nxt;

        always_comb begin
            state_nxt   = state;
            timer_nxt   = timer;
            ctr_clk_nxt = 1'b1;
            ctr_rst_nxt = 1'b0;
            busy_nxt    = 1'b0;
            done_nxt    = 1'b0;
            case (state)
                S_IDLE: begin
                    if (CLR_REQ[i]) begin
                        state_nxt   = S_CLR;
                        timer_nxt   = RST_LOAD;
                        ctr_rst_nxt = 1'b1;
                        busy_nxt    = 1'b1;
                    end else if (ADV_REQ[i]) begin
                        state_nxt   = S_ADV;
                        timer_nxt   = LOW_LOAD;
                        ctr_clk_nxt = 1'b0;
                        busy_nxt    = 1'b1;
                    end
                end
                S_ADV: begin
                    busy_nxt = 1'b1;
                    if (timer == 8'd0) begin
                        state_nxt = S_GAP;
                        timer_nxt = GAP_LOAD;
                    end else begin
                        timer_nxt   = timer - 8'd1;
                        ctr_clk_nxt = 1'b0;
                    end
                end
                S_CLR: begin
                    busy_nxt = 1'b1;
                    if (timer == 8'd0) begin
                        state_nxt = S_GAP;
                        timer_nxt = GAP_LOAD;
                    end else begin
                        timer_nxt   = timer - 8'd1;
                        ctr_rst_nxt = 1'b1;
                    end
                end
                S_GAP: begin
                    if (timer == 8'd0) begin
                        state_nxt = S_IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        timer_nxt = timer - 8'd1;
                        busy_nxt  = 1'b1;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end

        always_ff @(posedge CLK) begin
            if (RST) begin
                state     <= S_IDLE;
                timer     <= 8'd0;
                ctr_clk_q <= 1'b1;
                ctr_rst_q <= 1'b0;
                busy_q    <= 1'b0;
                done_q    <= 1'b0;
            end else begin
                state     <= state_nxt;
                timer     <= timer_nxt;
                ctr_clk_q <= ctr_clk_nxt;
                ctr_rst_q <= ctr_rst_nxt;
                busy_q    <= busy_nxt;
                done_q    <= done_nxt;
            end
        end

        assign CTR_CLK[i] = ctr_clk_q;
        assign CTR_RST[i] = ctr_rst_q;
        assign BUSY[i]    = busy_q;
        assign DONE[i]    = done_q;

`ifdef COUNTER_PULSE_SHADOW_EN
        logic [SHADOW_W-1:0] shadow_q;
        logic                adv_fin;
        logic                clr_fin;

        // Final cycle of each pulse phase is exactly the edge that moves to GAP.
        assign adv_fin = (state == S_ADV) && (timer == 8'd0);
        assign clr_fin = (state == S_CLR) && (timer == 8'd0);

        always_ff @(posedge CLK) begin
            if (RST || clr_fin) begin
                shadow_q <= '0;
            end else if (adv_fin) begin
                shadow_q <= shadow_q + SHADOW_W'(1);
            end
        end

        assign SHADOW_CNT[i*SHADOW_W +: SHADOW_W] = shadow_q;
`else
        assign SHADOW_CNT[i*SHADOW_W +: SHADOW_W] = '0;
`endif
    end

endmodule

// File: tb/tb_counter_pulse_ctrl.sv
// Directed bench for counter_pulse_ctrl; DONE strobes are matched against a scoreboard of expected operations.
module tb_counter_pulse_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic [3:0]  adv_req, clr_req, adv2, clr2;
    logic [3:0]  ctr_clk, ctr_rst, busy, done;
    logic [3:0]  ctr_clk2, ctr_rst2, busy2, done2;
    logic [31:0] shadow;
    logic [7:0]  shadow2;

    counter_pulse_ctrl dut (
        .CLK(CLK), .RST(RST), .ADV_REQ(adv_req), .CLR_REQ(clr_req),
        .CTR_CLK(ctr_clk), .CTR_RST(ctr_rst), .BUSY(busy), .DONE(done),
        .SHADOW_CNT(shadow)
    );

    counter_pulse_ctrl #(.SHADOW_W(2)) dut_w2 (
        .CLK(CLK), .RST(RST), .ADV_REQ(adv2), .CLR_REQ(clr2),
        .CTR_CLK(ctr_clk2), .CTR_RST(ctr_rst2), .BUSY(busy2), .DONE(done2),
        .SHADOW_CNT(shadow2)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int         ch;
        logic [7:0] shadow;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] sh_model[4];
    int         checks = 0;
    int         failures = 0;
    int         edge_n = 0;
    int         falls2 = 0;
    int         last_fall2 = -1;
    int         period_bad = 0;
    logic       prev_clk2 = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int ch, input bit is_clr);
`ifdef COUNTER_PULSE_SHADOW_EN
        sh_model[ch] = is_clr ? 8'd0 : sh_model[ch] + 8'd1;
`endif
        sb_q.push_back('{ch, sh_model[ch]});
    endtask

    // Advance one edge, then sample 1 time unit later and run the monitors.
    task automatic tick();
        int idx;
        @(posedge CLK);
        #1;
        edge_n++;
        chk("no_overlap", {28'd0, ~ctr_clk & ctr_rst}, 32'd0);
        for (int c = 0; c < 4; c++) begin
            if (done[c]) begin
                idx = -1;
                for (int j = 0; j < sb_q.size(); j++) begin
                    if (idx < 0 && sb_q[j].ch == c) idx = j;
                end
                chk($sformatf("sb_done_expected_ch%0d", c), {31'd0, idx >= 0}, 32'd1);
                if (idx >= 0) begin
                    chk($sformatf("sb_shadow_ch%0d", c), {24'd0, shadow[c*8 +: 8]}, {24'd0, sb_q[idx].shadow});
                    sb_q.delete(idx);
                end
            end
        end
        if (prev_clk2 && !ctr_clk[2]) begin
            falls2++;
            if (last_fall2 >= 0 && edge_n - last_fall2 != 4) period_bad++;
            last_fall2 = edge_n;
        end
        prev_clk2 = ctr_clk[2];
    endtask

    initial begin
        logic [1:0] w2_exp;
        RST = 1'b1;
        adv_req = '0; clr_req = '0; adv2 = '0; clr2 = '0;
        for (int c = 0; c < 4; c++) sh_model[c] = 8'd0;

        // Reset state
        repeat (3) tick();
        chk("rst_ctr_clk", {28'd0, ctr_clk}, 32'hF);
        chk("rst_ctr_rst", {28'd0, ctr_rst}, 32'h0);
        chk("rst_busy",    {28'd0, busy},    32'h0);
        chk("rst_done",    {28'd0, done},    32'h0);
        chk("rst_shadow",  shadow,           32'h0);
        RST = 1'b0;
        repeat (2) tick();

        // Single advance on channel 0
        adv_req[0] = 1'b1;
        tick();
        adv_req[0] = 1'b0;
        push_exp(0, 0);
        chk("adv_k_clk0",  {31'd0, ctr_clk[0]}, 32'd0);
        chk("adv_k_busy0", {31'd0, busy[0]},    32'd1);
        tick();
        chk("adv_k1_clk0", {31'd0, ctr_clk[0]}, 32'd0);
        chk("adv_k1_done0", {31'd0, done[0]},   32'd0);
        tick();
        chk("adv_k2_clk0",  {31'd0, ctr_clk[0]}, 32'd1);
        chk("adv_k2_busy0", {31'd0, busy[0]},    32'd1);
        chk("adv_k2_done0", {31'd0, done[0]},    32'd0);
        tick();
        chk("adv_k3_done0", {31'd0, done[0]}, 32'd1);
        chk("adv_k3_busy0", {31'd0, busy[0]}, 32'd0);
        tick();
        chk("adv_k4_done0", {31'd0, done[0]}, 32'd0);

        // Channel 1: advance, then simultaneous advance+clear (clear wins)
        adv_req[1] = 1'b1;
        tick();
        adv_req[1] = 1'b0;
        push_exp(1, 0);
        repeat (4) tick();
        adv_req[1] = 1'b1; clr_req[1] = 1'b1;
        tick();
        adv_req[1] = 1'b0; clr_req[1] = 1'b0;
        push_exp(1, 1);
        chk("clr_k_rst1", {31'd0, ctr_rst[1]}, 32'd1);
        chk("clr_k_clk1", {31'd0, ctr_clk[1]}, 32'd1);
        tick();
        chk("clr_k1_rst1", {31'd0, ctr_rst[1]}, 32'd1);
        chk("clr_k1_clk1", {31'd0, ctr_clk[1]}, 32'd1);
        tick();
        chk("clr_k2_rst1",  {31'd0, ctr_rst[1]}, 32'd0);
        chk("clr_k2_busy1", {31'd0, busy[1]},    32'd1);
        tick();
        chk("clr_k3_done1", {31'd0, done[1]}, 32'd1);
        chk("clr_shadow1",  {24'd0, shadow[15:8]}, 32'd0);
        tick();

        // Channel 2: request held for 20 edges
        for (int n = 0; n < 5; n++) push_exp(2, 0);
        adv_req[2] = 1'b1;
        repeat (20) tick();
        adv_req[2] = 1'b0;
        repeat (4) tick();
        chk("held_falls2",   falls2, 32'd5);
        chk("held_period2",  period_bad, 32'd0);
        chk("held_shadow2",  {24'd0, shadow[23:16]}, {24'd0, sh_model[2]});

        // Narrow shadow wraps on the SHADOW_W=2 instance
        for (int n = 0; n < 5; n++) begin
            adv2[3] = 1'b1;
            tick();
            adv2[3] = 1'b0;
            repeat (3) tick();
`ifdef COUNTER_PULSE_SHADOW_EN
            w2_exp = 2'(n + 1);
`else
            w2_exp = 2'd0;
`endif
            chk($sformatf("w2_shadow3_adv%0d", n + 1), {30'd0, shadow2[7:6]}, {30'd0, w2_exp});
        end

        // Clear on busy channel 0 is ignored; channel 1 timing is independent
        adv_req[0] = 1'b1; adv_req[1] = 1'b1;
        tick();
        adv_req[0] = 1'b0; adv_req[1] = 1'b0;
        clr_req[0] = 1'b1;
        push_exp(0, 0);
        push_exp(1, 0);
        chk("ign_k_clk1", {31'd0, ctr_clk[1]}, 32'd0);
        tick();
        clr_req[0] = 1'b0;
        chk("ign_k1_rst0", {31'd0, ctr_rst[0]}, 32'd0);
        chk("ign_k1_clk0", {31'd0, ctr_clk[0]}, 32'd0);
        chk("ign_k1_clk1", {31'd0, ctr_clk[1]}, 32'd0);
        tick();
        chk("ign_k2_clk1",  {31'd0, ctr_clk[1]}, 32'd1);
        chk("ign_k2_busy1", {31'd0, busy[1]},    32'd1);
        chk("ign_k2_rst0",  {31'd0, ctr_rst[0]}, 32'd0);
        tick();
        chk("ign_k3_done1", {31'd0, done[1]}, 32'd1);
        tick();
        chk("ign_rst0_after", {31'd0, ctr_rst[0]}, 32'd0);
        chk("ign_shadow0", {24'd0, shadow[7:0]}, {24'd0, sh_model[0]});

        // Reset during the second cycle of an advance pulse; request during reset dropped
        adv_req[0] = 1'b1;
        tick();
        adv_req[0] = 1'b0;
        chk("abort_k_clk0", {31'd0, ctr_clk[0]}, 32'd0);
        RST = 1'b1;
        adv_req[3] = 1'b1;
        tick();
        RST = 1'b0;
        adv_req[3] = 1'b0;
        for (int c = 0; c < 4; c++) sh_model[c] = 8'd0;
        chk("abort_clk0",   {31'd0, ctr_clk[0]}, 32'd1);
        chk("abort_busy0",  {31'd0, busy[0]},    32'd0);
        chk("abort_done0",  {31'd0, done[0]},    32'd0);
        chk("abort_shadow", shadow, 32'h0);
        for (int n = 0; n < 3; n++) begin
            tick();
            chk($sformatf("abort_nodone_%0d", n), {28'd0, done}, 32'h0);
            chk($sformatf("abort_busy3_%0d", n), {31'd0, busy[3]}, 32'd0);
        end

        chk("sb_empty", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
